// File: rtl/axi_interconnect_crossbar_wresp_router.sv
// Slave-side AW order queue steering W beats and routing B back
// to the master that owned each granted write address.
module axi_interconnect_crossbar_wresp_router #(
   parameter int NUM   = 2,
   parameter int WIDTH = (NUM > 2) ? $clog2(NUM) : 1,
   parameter int DEPTH = 4,
   parameter int PW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             aw_push,
   input  logic [WIDTH-1:0] aw_user,
   output logic             aw_allow,
   input  logic [NUM-1:0]   m_wvalid,
   input  logic [NUM-1:0]   m_wlast,
   output logic [NUM-1:0]   m_wready,
   output logic             s_wvalid,
   output logic             s_wlast,
   input  logic             s_wready,
   output logic [WIDTH-1:0] w_sel,
   input  logic             s_bvalid,
   output logic             s_bready,
   output logic [NUM-1:0]   m_bvalid,
   input  logic [NUM-1:0]   m_bready,
   output logic [WIDTH-1:0] b_sel
);

   localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      w_ptr;
   logic [PW:0]      b_ptr;
   logic [PW:0]      count;
   logic             full;
   logic             w_pend;
   logic             b_pend;
   logic             do_push;
   logic             do_w;
   logic             do_b;

   assign count    = wr_ptr - b_ptr;
   assign full     = (count == DEPTH_P);
   assign aw_allow = !full;

   assign w_pend = (w_ptr != wr_ptr);
   assign b_pend = (b_ptr != w_ptr);

   assign w_sel = w_pend ? mem[w_ptr[PW-1:0]] : '0;
   assign b_sel = b_pend ? mem[b_ptr[PW-1:0]] : '0;

   assign s_wvalid = w_pend & m_wvalid[w_sel];
   assign s_wlast  = w_pend & m_wlast[w_sel];
   assign s_bready = b_pend & m_bready[b_sel];

   always_comb begin
      m_wready = '0;
      m_bvalid = '0;
      if (w_pend && s_wready)
         m_wready[w_sel] = 1'b1;
      if (b_pend && s_bvalid)
         m_bvalid[b_sel] = 1'b1;
   end

   // push is gated by registered full only, so a same-cycle B pop
   // never frees a slot for the current AW
   assign do_push = aw_push & aw_allow;
   assign do_w    = s_wvalid & s_wready & s_wlast;
   assign do_b    = s_bvalid & s_bready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         w_ptr  <= '0;
         b_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= aw_user;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_w)
            w_ptr <= w_ptr + 1'b1;
         if (do_b)
            b_ptr <= b_ptr + 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_interconnect_crossbar_wresp_router.sv
// Randomized bench for the write-order router, checked each cycle
// against a queue model of outstanding W and B ownership.
module tb_axi_interconnect_crossbar_wresp_router;

   localparam int NUM   = 2;
   localparam int WIDTH = 1;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             aw_push;
   logic [WIDTH-1:0] aw_user;
   logic             aw_allow;
   logic [NUM-1:0]   m_wvalid;
   logic [NUM-1:0]   m_wlast;
   logic [NUM-1:0]   m_wready;
   logic             s_wvalid;
   logic             s_wlast;
   logic             s_wready;
   logic [WIDTH-1:0] w_sel;
   logic             s_bvalid;
   logic             s_bready;
   logic [NUM-1:0]   m_bvalid;
   logic [NUM-1:0]   m_bready;
   logic [WIDTH-1:0] b_sel;

   int total = 0;
   int bad = 0;
   int wq[$];
   int bq[$];
   int pushed[$];
   int bdone[$];

   axi_interconnect_crossbar_wresp_router #(
      .NUM(NUM), .WIDTH(WIDTH), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_push(aw_push), .aw_user(aw_user), .aw_allow(aw_allow),
      .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
      .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
      .w_sel(w_sel),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .b_sel(b_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", n, a, e);
      end
   endtask

   task automatic idle();
      aw_push  = 1'b0;
      aw_user  = '0;
      m_wvalid = '0;
      m_wlast  = '0;
      s_wready = 1'b0;
      s_bvalid = 1'b0;
      m_bready = '0;
   endtask

   task automatic cmp();
      int ws;
      int bs;
      bit wp;
      bit bp;
      logic [NUM-1:0] ewr;
      logic [NUM-1:0] ebv;
      wp  = wq.size() > 0;
      bp  = bq.size() > 0;
      ws  = wp ? wq[0] : 0;
      bs  = bp ? bq[0] : 0;
      ewr = '0;
      ebv = '0;
      if (wp && s_wready) ewr[ws] = 1'b1;
      if (bp && s_bvalid) ebv[bs] = 1'b1;
      chk("aw_allow", aw_allow, (wq.size() + bq.size()) < DEPTH);
      chk("w_sel", w_sel, ws);
      chk("b_sel", b_sel, bs);
      chk("s_wvalid", s_wvalid, wp && m_wvalid[ws]);
      chk("s_wlast", s_wlast, wp && m_wlast[ws]);
      chk("m_wready", m_wready, ewr);
      chk("m_bvalid", m_bvalid, ebv);
      chk("s_bready", s_bready, bp && m_bready[bs]);
   endtask

   task automatic cycle();
      bit dp;
      bit dw;
      bit db;
      @(negedge clk);
      cmp();
      dp = aw_push && ((wq.size() + bq.size()) < DEPTH);
      dw = wq.size() > 0 && m_wvalid[wq[0]] && m_wlast[wq[0]] && s_wready;
      db = bq.size() > 0 && s_bvalid && m_bready[bq[0]];
      @(posedge clk);
      if (db) bdone.push_back(bq.pop_front());
      if (dw) bq.push_back(wq.pop_front());
      if (dp) begin
         wq.push_back(int'(aw_user));
         pushed.push_back(int'(aw_user));
      end
      #1;
   endtask

   initial begin
      int exp_b[3];
      int budget;
      idle();
      #1;
      chk("rst_allow", aw_allow, 1);
      chk("rst_wvalid", s_wvalid, 0);
      chk("rst_bready", s_bready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();

      // single write from master 1, master 0 also asserts WVALID
      aw_push = 1'b1; aw_user = 1'b1;
      cycle();
      idle();
      m_wvalid = 2'b11; s_wready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m_wlast = (k == 3) ? 2'b11 : 2'b00;
         #1;
         chk("single_wready", m_wready, 2'b10);
         chk("single_wsel", w_sel, 1);
         cycle();
      end
      idle();
      s_bvalid = 1'b1; m_bready = 2'b11;
      #1;
      chk("single_bvalid", m_bvalid, 2'b10);
      chk("single_bsel", b_sel, 1);
      cycle();
      idle();
      cycle();

      // in-order interleave 0,1,0
      aw_push = 1'b1;
      aw_user = 1'b0; cycle();
      aw_user = 1'b1; cycle();
      aw_user = 1'b0; cycle();
      idle();
      m_wvalid = 2'b11; s_wready = 1'b1;
      #1;
      chk("inter_first_wready", m_wready, 2'b01);
      for (int k = 0; k < 6; k++) begin
         m_wlast = k[0] ? 2'b11 : 2'b00;
         cycle();
      end
      idle();
      s_bvalid = 1'b1; m_bready = 2'b11;
      exp_b = '{0, 1, 0};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("inter_bsel", b_sel, exp_b[k]);
         cycle();
      end
      idle();
      cycle();

      // fill, refuse the fifth AW, free one slot through a B
      aw_push = 1'b1;
      for (int k = 0; k < 4; k++) begin
         aw_user = k[0];
         cycle();
      end
      #1;
      chk("full_allow", aw_allow, 0);
      aw_user = 1'b1;
      cycle();
      idle();
      m_wvalid = 2'b11; m_wlast = 2'b11; s_wready = 1'b1;
      repeat (4) cycle();
      idle();
      chk("full_allow_wdone", aw_allow, 0);
      s_bvalid = 1'b1; m_bready = 2'b11;
      cycle();
      idle();
      chk("full_allow_after_b", aw_allow, 1);
      chk("model_count", wq.size() + bq.size(), 3);
      s_bvalid = 1'b1; m_bready = 2'b11;
      repeat (3) cycle();
      idle();
      cycle();

      // early B before WLAST
      aw_push = 1'b1; aw_user = 1'b0;
      cycle();
      idle();
      s_bvalid = 1'b1; m_bready = 2'b11;
      m_wvalid = 2'b01; s_wready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("early_bready", s_bready, 0);
         chk("early_bvalid", m_bvalid, 0);
         cycle();
      end
      m_wlast = 2'b01;
      #1;
      chk("early_bready_wlast", s_bready, 0);
      cycle();
      m_wvalid = '0; m_wlast = '0;
      #1;
      chk("early_bready_after", s_bready, 1);
      chk("early_bvalid_after", m_bvalid, 2'b01);
      cycle();
      idle();
      cycle();

      // reset mid-burst
      aw_push = 1'b1; aw_user = 1'b1; cycle();
      aw_user = 1'b0; cycle();
      idle();
      m_wvalid = 2'b11; s_wready = 1'b1; s_bvalid = 1'b1; m_bready = 2'b11;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_allow", aw_allow, 1);
      chk("mrst_wvalid", s_wvalid, 0);
      chk("mrst_wlast", s_wlast, 0);
      chk("mrst_wready", m_wready, 0);
      chk("mrst_bvalid", m_bvalid, 0);
      chk("mrst_bready", s_bready, 0);
      chk("mrst_wsel", w_sel, 0);
      chk("mrst_bsel", b_sel, 0);
      wq.delete();
      bq.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();
      #1;
      chk("mrst_post_wvalid", s_wvalid, 0);
      cycle();
      idle();

      // randomized traffic with wrap and simultaneous events
      pushed.delete();
      bdone.delete();
      for (int k = 0; k < 400; k++) begin
         aw_push  = ($urandom_range(0, 99) < 45);
         aw_user  = WIDTH'($urandom_range(0, NUM - 1));
         m_wvalid = NUM'($urandom);
         m_wlast  = NUM'($urandom);
         s_wready = ($urandom_range(0, 99) < 70);
         s_bvalid = ($urandom_range(0, 99) < 60);
         m_bready = NUM'($urandom);
         cycle();
      end
      idle();
      budget = 0;
      while ((wq.size() + bq.size()) > 0 && budget < 200) begin
         m_wvalid = 2'b11; m_wlast = 2'b11; s_wready = 1'b1;
         s_bvalid = 1'b1; m_bready = 2'b11;
         cycle();
         budget++;
      end
      idle();
      chk("drain_done", wq.size() + bq.size(), 0);
      chk("rand_push_count_min", pushed.size() >= 20, 1);
      chk("b_seq_len", bdone.size(), pushed.size());
      for (int k = 0; k < pushed.size() && k < bdone.size(); k++)
         chk("b_seq", bdone[k], pushed[k]);
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_interconnect_crossbar_wresp_router.md
# axi_interconnect_crossbar_wresp_router

Slave-side write-order tracker and response router for the crossbar. It takes each write-address grant produced by the round-robin polling arbiter and records the granted master index in an in-order queue. It then steers that master's W beats to the slave and routes the slave's B response back to the same master. One instance sits behind each slave port's AW arbiter, completing the path back from the arbiter's grant decision.

## Interface
- NUM, 2: number of masters sharing this slave port.
- WIDTH, LOG2(NUM-1): master index width. LOG2 returns the minimum n ≥ 1 with 2^n−1 ≥ d, identical to the arbiter's width function.
- DEPTH, 4: maximum outstanding write transactions; must be a power of 2, ≥ 2.
- PW, LOG2(DEPTH-1): queue index width; internal pointers are PW+1 bits.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- aw_push  in  1  granted AW handshake completed at the slave this cycle.
- aw_user  in  WIDTH  arbiter current_user for that AW.
- aw_allow  out  1  queue not full; upstream gates AW grant with it.
- m_wvalid  in  NUM  per-master WVALID.
- m_wlast  in  NUM  per-master WLAST.
- m_wready  out  NUM  per-master WREADY.
- s_wvalid  out  1  to slave.
- s_wlast  out  1  to slave.
- s_wready  in  1  from slave.
- w_sel  out  WIDTH  master index for the external WDATA/WSTRB mux.
- s_bvalid  in  1  from slave.
- s_bready  out  1  to slave.
- m_bvalid  out  NUM  per-master BVALID.
- m_bready  in  NUM  per-master BREADY.
- b_sel  out  WIDTH  master index for the external BRESP/BID demux.

## Operation
- Queue: DEPTH entries of WIDTH bits. It has three PW+1-bit pointers: wr_ptr (allocate), w_ptr (data head), and b_ptr (response head).
- Invariant: b_ptr ≤ w_ptr ≤ wr_ptr, with modular distance.
- count = wr_ptr − b_ptr, modulo 2^(PW+1). full = (count == DEPTH). aw_allow = !full.
- Push: on aw_push & aw_allow, the entry at wr_ptr[PW-1:0] is written with aw_user and wr_ptr increments. aw_push while full is a protocol violation and is ignored; no state changes.
- W routing: w_pend = (w_ptr != wr_ptr). w_sel = entry[w_ptr] when w_pend, else 0.
- s_wvalid = w_pend & m_wvalid[w_sel]. s_wlast = w_pend & m_wlast[w_sel].
- m_wready[i] = w_pend & (i == w_sel) & s_wready. All other masters see WREADY = 0.
- w_ptr increments on s_wvalid & s_wready & s_wlast.
- B routing: b_pend = (b_ptr != w_ptr). A response is routable only after its burst's WLAST has been accepted.
- b_sel = entry[b_ptr] when b_pend, else 0.
- m_bvalid[i] = b_pend & (i == b_sel) & s_bvalid. s_bready = b_pend & m_bready[b_sel].
- b_ptr increments on s_bvalid & s_bready. With no b_pend, s_bready = 0 and an early slave B stalls.
- Simultaneous events: push, W-last pop and B pop may all occur in one cycle, each pointer updating independently. A push when full is refused even if a B pop happens in the same cycle, because aw_allow depends only on registered state.
- w_sel, b_sel and aw_allow are decoded from registered state only; there is no combinational path from aw_push to them.

## Timing
- Reset (asynchronous assert, synchronous release): all pointers 0 and queue contents 0.
- Reset output values: aw_allow = 1; s_wvalid, s_wlast, s_bready = 0; m_wready, m_bvalid = 0; w_sel, b_sel = 0.
- Reset mid-transaction discards all outstanding entries.
- AW→W latency: a push in cycle N makes that entry routable for W in cycle N+1, or later if earlier bursts are still pending.
- W→B latency: WLAST accepted in cycle N makes the B response routable in cycle N+1.
- Ready/valid pass through combinationally with zero added latency while an entry is at the head.
- Full: after DEPTH pushes with no B pop, aw_allow = 0. It returns to 1 the cycle after the first B handshake.
- Pointer wrap: the PW+1-bit pointers wrap modulo 2·DEPTH, and full/empty stay correct across the wrap.

## Test plan
- Reset: assert rst_n = 0 mid-burst → all outputs immediately take their reset values and aw_allow = 1. After release, s_wvalid stays 0 with m_wvalid all 1.
- Single write, NUM = 2: aw_push with aw_user = 1, then master 1 sends 4 beats with WLAST on the 4th → m_wready = 2'b10. Master 0's WVALID is ignored. B goes only to m_bvalid = 2'b10, with b_sel = 1.
- In-order interleave: push users 0, 1, 0 back-to-back → W bursts are served strictly in the order 0, 1, 0, and B responses are routed 0, 1, 0. Master 1's data stalls until master 0's first WLAST.
- Full/backpressure, DEPTH = 4: 4 pushes with no B → aw_allow = 0. A 5th aw_push is ignored. One B handshake → aw_allow = 1 in the next cycle, and count = 3.
- Early B: slave asserts s_bvalid before WLAST → s_bready = 0 and m_bvalid = 0 until the cycle after WLAST is accepted.
- Wrap and simultaneity: 20 random transactions with push, WLAST and B in the same cycle, m_bready randomly throttled → the B master sequence equals the push sequence, with no lost or duplicated response.
